vcc_lexer: RTL and testbench
============================

Name: vcc_lexer

Overview:
- Streaming hardware tokenizer. Consumes a byte stream of C-subset source text and emits the token stream in the form the parser consumes: kinds reserved, ident, num and eof, each with a source position.
- Sits directly upstream of the parser front end. It is the producer side of the token interface.
- Recognises keywords, 1- and 2-character operators, decimal literals and identifiers. Skips whitespace. Flags lexical errors.

Parameters:
- NUM_W, 32: width of numeric literal value; literals must fit unsigned in NUM_W bits.
- MAX_ID, 16: maximum identifier length in characters.
- POS_W, 16: width of source byte offset counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  lexer accepts beat this cycle.
- in_char  in  8  ASCII character (ignored when in_eof=1).
- in_eof  in  1  end-of-stream beat, carries no character.
- tok_valid  out  1  token register full.
- tok_ready  in  1  consumer accepts token.
- tok_kind  out  2  0=reserved, 1=ident, 2=num, 3=eof.
- tok_code  out  5  reserved code (0 when kind!=reserved).
- tok_num  out  NUM_W  literal value (0 when kind!=num).
- tok_text  out  MAX_ID*8  ident chars; first char in [7:0]; bytes beyond tok_len are zero.
- tok_len  out  $clog2(MAX_ID+1)  ident length.
- tok_pos  out  POS_W  byte offset of the token's first char (eof: offset after the last char).
- err  out  1  sticky lexical error.
- err_code  out  2  1=illegal char, 2=number overflow, 3=ident too long.
- err_pos  out  POS_W  offset of the offending char/token start.

Behaviour:
- Clock and reset are fixed: one clock `clk`; `rst` is synchronous and active-high.
- Reset values: all outputs 0, in_ready=0 during reset. State returns to IDLE and the position counter clears to 0. Reset mid-token discards partial state.
- Handshakes:
  - Input beat transfers when in_valid & in_ready.
  - Token transfers when tok_valid & tok_ready.
  - While tok_valid is set, tok_* fields are held stable.
  - A new token may load in the same cycle the old one is accepted.
- in_ready=0 whenever the token register is full and not draining, and in states EOFD and ERR.
- Position counter increments per accepted character beat (not eof beats). It wraps modulo 2^POS_W.
- Reserved codes:
  - Operators: + 0, - 1, * 2, / 3, ( 4, ) 5, < 6, > 7, <= 8, >= 9, == 10, != 11, = 12, ; 13, { 14, } 15, , 16, [ 17, ] 18, & 19.
  - Keywords: int 20, return 21, if 22, else 23, for 24, while 25, sizeof 26.
- FSM states: IDLE, NUM, IDENT, OP2, EOFD, ERR.
- IDLE:
  - Whitespace (0x20, \t, \n, \r) is consumed and skipped.
  - Digit: start NUM, value=digit.
  - [A-Za-z_]: start IDENT with len=1.
  - < > = !: go to OP2 holding that char.
  - Other single-char ops: emit reserved token. tok_valid rises the cycle after acceptance (latency 1).
  - in_eof: emit eof token, go to EOFD.
  - Any other char: error 1.
- NUM:
  - Each digit computes value = value*10 + d. Overflow beyond 2^NUM_W-1 raises error 2.
  - A non-digit char or eof is NOT consumed (in_ready=0). The num token is emitted, then IDLE reprocesses that beat.
- IDENT:
  - [A-Za-z0-9_] appends a char. The (MAX_ID+1)th char raises error 3.
  - Any other char/eof is not consumed. On termination, text is compared against the keyword list: a match emits reserved with the keyword code, otherwise ident.
- OP2:
  - Next char '=' is consumed and emits <=, >=, == or !=.
  - Otherwise the held char emits alone (<, >, =) and the current beat is not consumed.
  - A lone '!' followed by non-'=' raises error 1 at the '!' position.
- EOFD: after the eof token is accepted, stays idle with in_ready=0 until reset.
- ERR:
  - Sets err, err_code and err_pos. Any pending valid token is still delivered.
  - No further tokens are produced; in_ready=0 until reset.
- Simultaneous tok accept and new token load: no bubble. Sustained throughput is 1 char/cycle for single-char ops.

Test Plan:
- "int x;" + eof, tok_ready=1 -> (reserved,20,pos0), (ident,"x",len1,pos4), (reserved,13,pos5), (eof,pos6).
- "a<=10>b" + eof -> ident a@0; reserved 8@1; num 10@3; reserved 7@5 with 'b' reprocessed; ident b@6; eof@7.
- "(1)" with tok_ready low 5 cycles after the first token -> tok_kind/code/pos held stable, in_ready=0, no token dropped or duplicated.
- NUM_W=32, "4294967295 4294967296" -> num 0xFFFFFFFF@0, then err=1, err_code=2, err_pos=11, no further tokens.
- "x @" -> ident x@0, then err_code=1, err_pos=2. Also "!x" -> err_code=1, err_pos=0.
- 17-char identifier -> err_code=3. Assert rst mid-identifier "whi" -> all outputs 0. Then "while" after reset -> reserved 25@0.

Source files
------------

// File: rtl/vcc_lexer.sv
// vcc_lexer: streaming tokenizer for a C subset. Takes one source byte per
// beat and produces reserved / ident / num / eof tokens tagged with the byte
// offset of their first character.
// Handshake: a beat moves when in_valid & in_ready, a token moves when
// tok_valid & tok_ready; a held token keeps every tok_* field stable.
module vcc_lexer #(
    parameter int NUM_W  = 32,
    parameter int MAX_ID = 16,
    parameter int POS_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_char,
    input  logic                         in_eof,
    output logic                         tok_valid,
    input  logic                         tok_ready,
    output logic [1:0]                   tok_kind,
    output logic [4:0]                   tok_code,
    output logic [NUM_W-1:0]             tok_num,
    output logic [MAX_ID*8-1:0]          tok_text,
    output logic [$clog2(MAX_ID+1)-1:0]  tok_len,
    output logic [POS_W-1:0]             tok_pos,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [POS_W-1:0]             err_pos
);

    localparam int LEN_W = $clog2(MAX_ID + 1);
    localparam int TXT_W = MAX_ID * 8;
    localparam logic [1:0] K_RSV = 2'd0;
    localparam logic [1:0] K_ID  = 2'd1;
    localparam logic [1:0] K_NUM = 2'd2;
    localparam logic [1:0] K_EOF = 2'd3;
    localparam logic [NUM_W+3:0] TEN = (NUM_W + 4)'(10);

    typedef enum logic [2:0] {S_IDLE, S_NUM, S_IDENT, S_OP2, S_EOFD, S_ERR} state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d, start_q, start_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [TXT_W-1:0]   text_q, text_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [7:0]         hold_q, hold_d;
    logic               tok_valid_q, tok_valid_d;
    logic [1:0]         tok_kind_q, tok_kind_d;
    logic [4:0]         tok_code_q, tok_code_d;
    logic [NUM_W-1:0]   tok_num_q, tok_num_d;
    logic [TXT_W-1:0]   tok_text_q, tok_text_d;
    logic [LEN_W-1:0]   tok_len_q, tok_len_d;
    logic [POS_W-1:0]   tok_pos_q, tok_pos_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [POS_W-1:0]   err_pos_q, err_pos_d;

    logic               can_load, in_ready_c;
    logic               is_ws, is_dig, is_alpha, op1_hit, kw_hit;
    logic [4:0]         op1_code, kw_code;
    logic [NUM_W+3:0]   num_wide;
    logic               ld;
    logic [1:0]         ld_kind;
    logic [4:0]         ld_code;
    logic [NUM_W-1:0]   ld_num;
    logic [TXT_W-1:0]   ld_text;
    logic [LEN_W-1:0]   ld_len;
    logic [POS_W-1:0]   ld_pos;

    // The token register can take a new token if empty or draining this cycle.
    assign can_load = !tok_valid_q || tok_ready;

    // Character classes, running decimal value and single-char operator table.
    always_comb begin
        is_ws    = (in_char == 8'h20) || (in_char == 8'h09) || (in_char == 8'h0a) || (in_char == 8'h0d);
        is_dig   = (in_char >= "0") && (in_char <= "9");
        is_alpha = ((in_char >= "a") && (in_char <= "z")) || ((in_char >= "A") && (in_char <= "Z")) || (in_char == "_");
        num_wide = ({4'b0000, num_q} * TEN) + {{NUM_W{1'b0}}, in_char[3:0]};
        op1_hit  = 1'b1;
        op1_code = 5'd0;
        case (in_char)
            "+": op1_code = 5'd0;
            "-": op1_code = 5'd1;
            "*": op1_code = 5'd2;
            "/": op1_code = 5'd3;
            "(": op1_code = 5'd4;
            ")": op1_code = 5'd5;
            ";": op1_code = 5'd13;
            "{": op1_code = 5'd14;
            "}": op1_code = 5'd15;
            ",": op1_code = 5'd16;
            "[": op1_code = 5'd17;
            "]": op1_code = 5'd18;
            "&": op1_code = 5'd19;
            default: op1_hit = 1'b0;
        endcase
    end

    // Keyword lookup on the collected identifier (first char sits in the low byte).
    always_comb begin
        kw_hit  = 1'b1;
        kw_code = 5'd0;
        if      (len_q == LEN_W'(3) && text_q[23:0] == "tni")    kw_code = 5'd20;
        else if (len_q == LEN_W'(6) && text_q[47:0] == "nruter") kw_code = 5'd21;
        else if (len_q == LEN_W'(2) && text_q[15:0] == "fi")     kw_code = 5'd22;
        else if (len_q == LEN_W'(4) && text_q[31:0] == "esle")   kw_code = 5'd23;
        else if (len_q == LEN_W'(3) && text_q[23:0] == "rof")    kw_code = 5'd24;
        else if (len_q == LEN_W'(5) && text_q[39:0] == "elihw")  kw_code = 5'd25;
        else if (len_q == LEN_W'(6) && text_q[47:0] == "foezis") kw_code = 5'd26;
        else kw_hit = 1'b0;
    end

    // Lexer FSM next state, token load decision and token register next value.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        start_d    = start_q;
        num_d      = num_q;
        text_d     = text_q;
        len_d      = len_q;
        hold_d     = hold_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_pos_d  = err_pos_q;
        in_ready_c = 1'b0;
        ld         = 1'b0;
        ld_kind    = K_RSV;
        ld_code    = 5'd0;
        ld_num     = '0;
        ld_text    = '0;
        ld_len     = '0;
        ld_pos     = pos_q;
        case (state_q)
            S_IDLE: begin
                in_ready_c = can_load;
                if (in_valid && can_load) begin
                    if (in_eof) begin
                        ld      = 1'b1;
                        ld_kind = K_EOF;
                        state_d = S_EOFD;
                    end else begin
                        pos_d   = pos_q + 1'b1;
                        start_d = pos_q;
                        if (is_ws) begin
                            state_d = S_IDLE;
                        end else if (is_dig) begin
                            num_d   = {{(NUM_W-4){1'b0}}, in_char[3:0]};
                            state_d = S_NUM;
                        end else if (is_alpha) begin
                            text_d  = {{(TXT_W-8){1'b0}}, in_char};
                            len_d   = LEN_W'(1);
                            state_d = S_IDENT;
                        end else if (in_char == "<" || in_char == ">" || in_char == "=" || in_char == "!") begin
                            hold_d  = in_char;
                            state_d = S_OP2;
                        end else if (op1_hit) begin
                            ld      = 1'b1;
                            ld_code = op1_code;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = 2'd1;
                            err_pos_d  = pos_q;
                            state_d    = S_ERR;
                        end
                    end
                end
            end
            S_NUM: begin
                in_ready_c = can_load && !in_eof && is_dig;
                if (in_valid && can_load) begin
                    if (!in_eof && is_dig) begin
                        pos_d = pos_q + 1'b1;
                        if (num_wide[NUM_W+3:NUM_W] != 4'd0) begin
                            err_d      = 1'b1;
                            err_code_d = 2'd2;
                            err_pos_d  = start_q;
                            state_d    = S_ERR;
                        end else begin
                            num_d = num_wide[NUM_W-1:0];
                        end
                    end else begin
                        // Terminator stays on the input for IDLE to reprocess.
                        ld      = 1'b1;
                        ld_kind = K_NUM;
                        ld_num  = num_q;
                        ld_pos  = start_q;
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDENT: begin
                in_ready_c = can_load && !in_eof && (is_alpha || is_dig);
                if (in_valid && can_load) begin
                    if (!in_eof && (is_alpha || is_dig)) begin
                        pos_d = pos_q + 1'b1;
                        if (len_q == LEN_W'(MAX_ID)) begin
                            err_d      = 1'b1;
                            err_code_d = 2'd3;
                            err_pos_d  = start_q;
                            state_d    = S_ERR;
                        end else begin
                            for (int i = 0; i < MAX_ID; i++) begin
                                if (len_q == i[LEN_W-1:0]) text_d[i*8 +: 8] = in_char;
                            end
                            len_d = len_q + 1'b1;
                        end
                    end else begin
                        ld      = 1'b1;
                        ld_kind = kw_hit ? K_RSV : K_ID;
                        ld_code = kw_code;
                        ld_text = kw_hit ? '0 : text_q;
                        ld_len  = kw_hit ? '0 : len_q;
                        ld_pos  = start_q;
                        state_d = S_IDLE;
                    end
                end
            end
            S_OP2: begin
                in_ready_c = can_load && !in_eof && (in_char == "=");
                if (in_valid && can_load) begin
                    ld     = 1'b1;
                    ld_pos = start_q;
                    state_d = S_IDLE;
                    if (!in_eof && in_char == "=") begin
                        pos_d = pos_q + 1'b1;
                        case (hold_q)
                            "<":     ld_code = 5'd8;
                            ">":     ld_code = 5'd9;
                            "=":     ld_code = 5'd10;
                            default: ld_code = 5'd11;
                        endcase
                    end else if (hold_q == "!") begin
                        ld         = 1'b0;
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                        err_pos_d  = start_q;
                        state_d    = S_ERR;
                    end else begin
                        case (hold_q)
                            "<":     ld_code = 5'd6;
                            ">":     ld_code = 5'd7;
                            default: ld_code = 5'd12;
                        endcase
                    end
                end
            end
            default: in_ready_c = 1'b0;
        endcase
        tok_valid_d = tok_valid_q && !tok_ready;
        tok_kind_d  = tok_kind_q;
        tok_code_d  = tok_code_q;
        tok_num_d   = tok_num_q;
        tok_text_d  = tok_text_q;
        tok_len_d   = tok_len_q;
        tok_pos_d   = tok_pos_q;
        if (ld) begin
            tok_valid_d = 1'b1;
            tok_kind_d  = ld_kind;
            tok_code_d  = ld_code;
            tok_num_d   = ld_num;
            tok_text_d  = ld_text;
            tok_len_d   = ld_len;
            tok_pos_d   = ld_pos;
        end
    end

    // State and output registers; reset drops any partial token.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            start_q     <= '0;
            num_q       <= '0;
            text_q      <= '0;
            len_q       <= '0;
            hold_q      <= '0;
            tok_valid_q <= 1'b0;
            tok_kind_q  <= '0;
            tok_code_q  <= '0;
            tok_num_q   <= '0;
            tok_text_q  <= '0;
            tok_len_q   <= '0;
            tok_pos_q   <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            err_pos_q   <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            start_q     <= start_d;
            num_q       <= num_d;
            text_q      <= text_d;
            len_q       <= len_d;
            hold_q      <= hold_d;
            tok_valid_q <= tok_valid_d;
            tok_kind_q  <= tok_kind_d;
            tok_code_q  <= tok_code_d;
            tok_num_q   <= tok_num_d;
            tok_text_q  <= tok_text_d;
            tok_len_q   <= tok_len_d;
            tok_pos_q   <= tok_pos_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_pos_q   <= err_pos_d;
        end
    end

    assign in_ready  = in_ready_c && !rst;
    assign tok_valid = tok_valid_q;
    assign tok_kind  = tok_kind_q;
    assign tok_code  = tok_code_q;
    assign tok_num   = tok_num_q;
    assign tok_text  = tok_text_q;
    assign tok_len   = tok_len_q;
    assign tok_pos   = tok_pos_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_pos   = err_pos_q;

endmodule

// File: tb/tb_vcc_lexer.sv
// Bench for vcc_lexer: directed sources plus random token soup, checked
// against a software lexer that scans the source string directly.
module tb_vcc_lexer;

    localparam int NUM_W  = 32;
    localparam int MAX_ID = 16;
    localparam int POS_W  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_char = 8'h00;
    logic          in_eof = 1'b0;
    logic          tok_valid;
    logic          tok_ready = 1'b0;
    logic [1:0]    tok_kind;
    logic [4:0]    tok_code;
    logic [31:0]   tok_num;
    logic [127:0]  tok_text;
    logic [4:0]    tok_len;
    logic [15:0]   tok_pos;
    logic          err;
    logic [1:0]    err_code;
    logic [15:0]   err_pos;

    // Clock and reset
    always #5 clk = ~clk;

    vcc_lexer #(.NUM_W(NUM_W), .MAX_ID(MAX_ID), .POS_W(POS_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_eof(in_eof),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_kind(tok_kind), .tok_code(tok_code), .tok_num(tok_num),
        .tok_text(tok_text), .tok_len(tok_len), .tok_pos(tok_pos),
        .err(err), .err_code(err_code), .err_pos(err_pos)
    );

    typedef struct packed {
        logic [1:0]   kind;
        logic [4:0]   code;
        logic [31:0]  num;
        logic [127:0] text;
        logic [4:0]   len;
        logic [15:0]  pos;
    } tok_t;

    tok_t        exp_q[$];
    logic        exp_err;
    logic [1:0]  exp_err_code;
    logic [15:0] exp_err_pos;
    int          n_checks = 0;
    int          n_fail = 0;

    string kws[7] = '{"int", "return", "if", "else", "for", "while", "sizeof"};
    string ops[24] = '{"+", "-", "*", "/", "(", ")", "<", ">", "<=", ">=", "==", "!=",
                       "=", ";", "{", "}", ",", "[", "]", "&", "!", "<", "=", ">"};

    // Scoreboard compare
    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference lexer
    function automatic bit c_dig(logic [7:0] c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic bit c_alpha(logic [7:0] c);
        return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || c == "_";
    endfunction

    function automatic bit c_ws(logic [7:0] c);
        return c == 8'h20 || c == 8'h09 || c == 8'h0a || c == 8'h0d;
    endfunction

    function automatic int kw_of(string w);
        for (int k = 0; k < 7; k++) if (w == kws[k]) return 20 + k;
        return -1;
    endfunction

    function automatic int op1_of(logic [7:0] c);
        case (c)
            "+": return 0;  "-": return 1;  "*": return 2;  "/": return 3;
            "(": return 4;  ")": return 5;  ";": return 13; "{": return 14;
            "}": return 15; ",": return 16; "[": return 17; "]": return 18;
            "&": return 19;
            default: return -1;
        endcase
    endfunction

    task automatic push_tok(input int kind, input int code, input logic [31:0] num,
                            input string w, input int pos);
        tok_t t;
        t = '0;
        t.kind = 2'(kind);
        t.code = 5'(code);
        t.num  = num;
        t.pos  = 16'(pos);
        if (kind == 1) begin
            t.len = 5'(w.len());
            for (int k = 0; k < w.len(); k++) t.text[k*8 +: 8] = w[k];
        end
        exp_q.push_back(t);
    endtask

    task automatic set_err(input int code, input int pos);
        exp_err = 1'b1;
        exp_err_code = 2'(code);
        exp_err_pos = 16'(pos);
    endtask

    task automatic build_model(input string s);
        int i, n, st, code;
        longint v;
        logic [7:0] c;
        exp_q.delete();
        exp_err = 1'b0;
        exp_err_code = 2'd0;
        exp_err_pos = 16'd0;
        n = s.len();
        i = 0;
        while (i < n) begin
            c = s[i];
            if (c_ws(c)) begin
                i++;
            end else if (c_dig(c)) begin
                st = i;
                v = 0;
                while (i < n && c_dig(s[i])) begin
                    v = v * 10 + (longint'(s[i]) - 48);
                    if (v > 64'hFFFF_FFFF) begin set_err(2, st); return; end
                    i++;
                end
                push_tok(2, 0, v[31:0], "", st);
            end else if (c_alpha(c)) begin
                st = i;
                while (i < n && (c_alpha(s[i]) || c_dig(s[i]))) begin
                    if (i - st == MAX_ID) begin set_err(3, st); return; end
                    i++;
                end
                code = kw_of(s.substr(st, i - 1));
                if (code >= 0) push_tok(0, code, 0, "", st);
                else push_tok(1, 0, 0, s.substr(st, i - 1), st);
            end else if (c == "<" || c == ">" || c == "=" || c == "!") begin
                if (i + 1 < n && s[i+1] == "=") begin
                    code = (c == "<") ? 8 : (c == ">") ? 9 : (c == "=") ? 10 : 11;
                    push_tok(0, code, 0, "", i);
                    i += 2;
                end else if (c == "!") begin
                    set_err(1, i);
                    return;
                end else begin
                    code = (c == "<") ? 6 : (c == ">") ? 7 : 12;
                    push_tok(0, code, 0, "", i);
                    i++;
                end
            end else begin
                code = op1_of(c);
                if (code < 0) begin set_err(1, i); return; end
                push_tok(0, code, 0, "", i);
                i++;
            end
        end
        push_tok(3, 0, 0, "", n);
    endtask

    // Driver tasks
    task automatic check_zero(input string tag);
        check_eq({tag, ".tok_valid"}, tok_valid, 0);
        check_eq({tag, ".tok_kind"}, tok_kind, 0);
        check_eq({tag, ".tok_code"}, tok_code, 0);
        check_eq({tag, ".tok_num"}, tok_num, 0);
        check_eq({tag, ".tok_text"}, tok_text, 0);
        check_eq({tag, ".tok_len"}, tok_len, 0);
        check_eq({tag, ".tok_pos"}, tok_pos, 0);
        check_eq({tag, ".err"}, err, 0);
        check_eq({tag, ".err_code"}, err_code, 0);
        check_eq({tag, ".err_pos"}, err_pos, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_eof = 1'b0;
        tok_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst.in_ready", in_ready, 0);
        check_zero("rst");
        rst = 1'b0;
    endtask

    task automatic cmp_tok(input string tag, input tok_t e);
        check_eq({tag, ".kind"}, tok_kind, e.kind);
        check_eq({tag, ".code"}, tok_code, e.code);
        check_eq({tag, ".num"}, tok_num, e.num);
        check_eq({tag, ".pos"}, tok_pos, e.pos);
        if (e.kind == 2'd1) begin
            check_eq({tag, ".len"}, tok_len, e.len);
            check_eq({tag, ".text"}, tok_text, e.text);
        end
    endtask

    // mode 0: full rate; 1: random valid/ready; 2: full rate, 5-cycle consumer stall after first token
    task automatic run_case(input string name, input string s, input int mode,
                            input bit with_rst, output int cycles);
        int idx, n, cyc, budget, stall_left, ntok;
        bit tok_seen, done, hold_prev;
        tok_t prev, got;
        build_model(s);
        if (with_rst) do_reset();
        n = s.len();
        idx = 0; cyc = 0; budget = 40 * n + 200; stall_left = 5; ntok = 0;
        tok_seen = 0; done = 0; hold_prev = 0; prev = '0;
        while (!done && cyc < budget) begin
            in_valid = (idx <= n) && (mode != 1 || $urandom_range(0, 3) != 0);
            in_eof = (idx == n);
            in_char = (idx < n) ? s[idx] : 8'($urandom_range(0, 255));
            if (mode == 1) tok_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && tok_seen && stall_left > 0) begin tok_ready = 1'b0; stall_left--; end
            else tok_ready = 1'b1;
            #1;
            got = {tok_kind, tok_code, tok_num, tok_text, tok_len, tok_pos};
            if (hold_prev) begin
                check_eq({name, ".hold.valid"}, tok_valid, 1);
                check_eq({name, ".hold.fields"}, got, prev);
            end
            if (tok_valid && !tok_ready) check_eq({name, ".in_ready_full"}, in_ready, 0);
            if (err) check_eq({name, ".in_ready_err"}, in_ready, 0);
            if (tok_valid && tok_ready) begin
                if (exp_q.size() == 0) check_eq({name, ".extra_tok"}, tok_valid, 0);
                else cmp_tok($sformatf("%s.t%0d", name, ntok), exp_q.pop_front());
                ntok++;
                if (tok_kind == 2'd3) done = 1;
            end
            if (tok_valid) tok_seen = 1;
            hold_prev = tok_valid && !tok_ready;
            prev = got;
            if (in_valid && in_ready) idx++;
            if (err && !tok_valid) done = 1;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        #1;
        check_eq({name, ".finished"}, done, 1);
        check_eq({name, ".missing_toks"}, exp_q.size(), 0);
        check_eq({name, ".err"}, err, exp_err);
        check_eq({name, ".err_code"}, err_code, exp_err_code);
        check_eq({name, ".err_pos"}, err_pos, exp_err_pos);
        cycles = cyc;
    endtask

    function automatic string rand_ident(int len);
        string a = "abcdefghijklmnopqrstuvwxyzABCXYZ_";
        string d = "0123456789";
        string s = "";
        int k;
        for (int j = 0; j < len; j++) begin
            if (j > 0 && $urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 9);
                s = {s, d.substr(k, k)};
            end else begin
                k = $urandom_range(0, a.len() - 1);
                s = {s, a.substr(k, k)};
            end
        end
        return s;
    endfunction

    function automatic string rand_src();
        string soup = "ab_Z9 \t\n\r<>=!@#$+;";
        string big[3] = '{"4294967295", "4294967296", "99999999999"};
        string s = "";
        int nf, k;
        nf = $urandom_range(1, 10);
        for (int f = 0; f < nf; f++) begin
            case ($urandom_range(0, 9))
                0: s = {s, kws[$urandom_range(0, 6)]};
                1, 2: s = {s, rand_ident(($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(1, 4))};
                3: s = {s, ($urandom_range(0, 5) == 0) ? big[$urandom_range(0, 2)] : $sformatf("%0d", $urandom_range(0, 100000))};
                4, 5: s = {s, ops[$urandom_range(0, 23)]};
                6, 7, 9: s = {s, " "};
                default: begin
                    k = $urandom_range(0, soup.len() - 1);
                    s = {s, soup.substr(k, k)};
                end
            endcase
        end
        return s;
    endfunction

    // Stimulus
    initial begin
        int cyc;
        string s;
        run_case("decl", "int x;", 0, 1, cyc);
        run_case("op2mix", "a<=10>b", 0, 1, cyc);
        run_case("stall", "(1)", 2, 1, cyc);
        run_case("ovf", "4294967295 4294967296", 0, 1, cyc);
        run_case("badch", "x @", 0, 1, cyc);
        run_case("bang", "!x", 0, 1, cyc);
        run_case("id17", "abcdefghijklmnopq", 0, 1, cyc);
        run_case("id16", "abcdefghijklmnop", 0, 1, cyc);
        run_case("kwlist", "if else for return sizeof int whilex", 1, 1, cyc);
        run_case("cmp", "a=b==c!=d>=e<f>", 0, 1, cyc);
        run_case("thru", "+-*/", 0, 1, cyc);
        check_eq("thru.cycles_ok", cyc <= 7, 1);

        // Reset in the middle of an identifier, then lex again without another reset.
        do_reset();
        tok_ready = 1'b1;
        s = "whi";
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_eof = 1'b0;
            in_char = s[k];
            #1;
            check_eq("mid.in_ready", in_ready, 1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("mid.rst_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_zero("mid_rst");
        rst = 1'b0;
        run_case("while_after_rst", "while", 0, 0, cyc);

        for (int r = 0; r < 50; r++) begin
            run_case($sformatf("rnd%0d", r), rand_src(), r % 2, 1, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Final report on a runaway simulation
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
